// File: rtl/multi_timer_core.sv
// multi_timer_core
//   NUM_CH independent CNT_W-bit timers that share one programmable prescaler.
//   Each channel can count up or down, run one-shot or periodic, and raises a
//   sticky terminal-count flag. The flag is combined through a mask into irq_any.
//
// Ports
//   clk, rstn   : system clock; asynchronous active-low reset
//   prescale    : a tick is produced every prescale+1 clk cycles
//   start       : per-channel pulse that loads load_val and sets the channel running
//   stop        : per-channel pulse that halts the channel and holds its count
//   irq_clear   : per-channel pulse that clears the sticky irq
//   oneshot     : per channel, 1 = one-shot, 0 = periodic
//   count_down  : per channel, 1 = count down, 0 = count up
//   irq_en      : per-channel mask applied when forming irq_any
//   load_val    : reload values; channel i is at [i*CNT_W +: CNT_W]
//   cur_count   : current counts, packed the same way as load_val
//   running     : per-channel run status
//   irq         : per-channel sticky terminal-count flags (unmasked)
//   irq_any     : registered OR of (irq & irq_en)
module multi_timer_core #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         irq_clear,
  input  logic [NUM_CH-1:0]         oneshot,
  input  logic [NUM_CH-1:0]         count_down,
  input  logic [NUM_CH-1:0]         irq_en,
  input  logic [NUM_CH*CNT_W-1:0]   load_val,
  output logic [NUM_CH*CNT_W-1:0]   cur_count,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         irq,
  output logic                      irq_any
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [NUM_CH-1:0]  at_term;
  logic [NUM_CH-1:0]  fire;

  // Shared prescaler: free-running from reset. Lowering prescale below the
  // current count makes it wrap through all-ones before the next tick.
  assign tick = (presc_cnt == prescale);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // A terminal event is a counting tick taken while the count sits at its
  // terminal value. A start or stop pulse in the same cycle suppresses counting.
  always_comb begin
    at_term = '0;
    fire    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      at_term[i] = count_down[i] ? (cnt_q[i] == '0) : (cnt_q[i] == '1);
      fire[i]    = tick & running[i] & ~start[i] & ~stop[i] & at_term[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      running <= '0;
      irq     <= '0;
      irq_any <= 1'b0;
    end else begin
      irq_any <= |(irq & irq_en);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (start[i]) begin
          // start always loads; a simultaneous stop leaves the channel halted
          cnt_q[i]   <= load_val[i*CNT_W +: CNT_W];
          running[i] <= ~stop[i];
        end else if (stop[i]) begin
          running[i] <= 1'b0;
        end else if (tick && running[i]) begin
          if (at_term[i]) begin
            if (oneshot[i]) begin
              running[i] <= 1'b0;
            end else begin
              cnt_q[i] <= load_val[i*CNT_W +: CNT_W];
            end
          end else if (count_down[i]) begin
            cnt_q[i] <= cnt_q[i] - 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end

        // setting the flag takes priority over a coincident clear
        if (fire[i]) begin
          irq[i] <= 1'b1;
        end else if (irq_clear[i]) begin
          irq[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cur_count = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_multi_timer_core.sv
module tb_multi_timer_core;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;

  // main instance: 4 channels, 32-bit counters, 8-bit prescaler
  logic [7:0]   prescale = '0;
  logic [3:0]   start = '0, stop = '0, irq_clear = '0;
  logic [3:0]   oneshot = '0, count_down = '0, irq_en = '0;
  logic [127:0] load_val = '0;
  logic [127:0] cur_count;
  logic [3:0]   running, irq;
  logic         irq_any;

  // small instance: 1 channel, 8-bit counter, 4-bit prescaler
  logic [3:0]   prescale_b = '0;
  logic [0:0]   start_b = '0, stop_b = '0, irq_clear_b = '0;
  logic [0:0]   oneshot_b = '0, count_down_b = '0, irq_en_b = '0;
  logic [7:0]   load_b = '0;
  logic [7:0]   cur_b;
  logic [0:0]   running_b, irq_b;
  logic         irq_any_b;

  int unsigned  vectors = 0;
  int unsigned  errs = 0;

  always #5 clk = ~clk;

  multi_timer_core dut (
    .clk(clk), .rstn(rstn), .prescale(prescale), .start(start), .stop(stop),
    .irq_clear(irq_clear), .oneshot(oneshot), .count_down(count_down),
    .irq_en(irq_en), .load_val(load_val), .cur_count(cur_count),
    .running(running), .irq(irq), .irq_any(irq_any)
  );

  multi_timer_core #(.NUM_CH(1), .CNT_W(8), .PRESC_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .prescale(prescale_b), .start(start_b), .stop(stop_b),
    .irq_clear(irq_clear_b), .oneshot(oneshot_b), .count_down(count_down_b),
    .irq_en(irq_en_b), .load_val(load_b), .cur_count(cur_b),
    .running(running_b), .irq(irq_b), .irq_any(irq_any_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A step is computed in 64-bit arithmetic; leaving the 32-bit range
  // (below 0 or above all-ones) is what makes a terminal event.
  logic [7:0]  m_pc, n_pc;
  logic [31:0] m_cnt [4];
  logic [31:0] n_cnt [4];
  logic [3:0]  m_run, n_run, m_irq, n_irq;
  logic        m_any, n_any, m_tick;
  longint      nxt;
  logic [31:0] lv;

  always_comb begin
    m_tick = (m_pc == prescale);
    n_pc   = m_tick ? 8'd0 : m_pc + 8'd1;
    n_any  = |(m_irq & irq_en);
    n_run  = m_run;
    n_irq  = m_irq;
    nxt    = 0;
    lv     = '0;
    for (int i = 0; i < 4; i++) begin
      n_cnt[i] = m_cnt[i];
      lv = load_val[i*32 +: 32];
      if (irq_clear[i]) n_irq[i] = 1'b0;
      if (start[i]) begin
        n_cnt[i] = lv;
        n_run[i] = !stop[i];
      end else if (stop[i]) begin
        n_run[i] = 1'b0;
      end else if (m_tick && m_run[i]) begin
        nxt = count_down[i] ? longint'(m_cnt[i]) - 1 : longint'(m_cnt[i]) + 1;
        if (nxt < 0 || nxt > 64'h0000_0000_FFFF_FFFF) begin
          n_irq[i] = 1'b1;
          if (oneshot[i]) n_run[i] = 1'b0;
          else            n_cnt[i] = lv;
        end else begin
          n_cnt[i] = nxt[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pc <= '0; m_run <= '0; m_irq <= '0; m_any <= 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
    end else begin
      m_pc <= n_pc; m_run <= n_run; m_irq <= n_irq; m_any <= n_any;
      for (int i = 0; i < 4; i++) m_cnt[i] <= n_cnt[i];
    end
  end

  // every-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_cnt%0d", i), cur_count[i*32 +: 32], m_cnt[i]);
    end
    chk("model_running", {28'd0, running}, {28'd0, m_run});
    chk("model_irq", {28'd0, irq}, {28'd0, m_irq});
    chk("model_irq_any", {31'd0, irq_any}, {31'd0, m_any});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    start = '0; stop = '0; irq_clear = '0; start_b = '0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_load(input int ch, input logic [31:0] v);
    load_val[ch*32 +: 32] = v;
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) @(negedge clk);
    chk("reset_cnt0", cur_count[31:0], 32'h0);
    chk("reset_running", {28'd0, running}, 32'h0);
    chk("reset_irq_any", {31'd0, irq_any}, 32'h0);
    rstn = 1'b1;
    step();

    // up / periodic wrap through all-ones with immediate reload
    prescale = 8'd0; irq_en = 4'b0001;
    set_load(0, 32'hFFFF_FFFD); start = 4'b0001;
    step(); chk("t1_load", cur_count[31:0], 32'hFFFF_FFFD);
    chk("t1_running", {31'd0, running[0]}, 32'h1);
    step(); chk("t1_c1", cur_count[31:0], 32'hFFFF_FFFE);
    step(); chk("t1_c2", cur_count[31:0], 32'hFFFF_FFFF);
    chk("t1_irq_pre", {31'd0, irq[0]}, 32'h0);
    step(); chk("t1_reload", cur_count[31:0], 32'hFFFF_FFFD);
    chk("t1_irq", {31'd0, irq[0]}, 32'h1);
    chk("t1_any_lag", {31'd0, irq_any}, 32'h0);
    step(); chk("t1_any", {31'd0, irq_any}, 32'h1);
    stop = 4'b0001; step();
    irq_clear = 4'b0001; step();

    // prescaled down / one-shot
    prescale = 8'd3; count_down[1] = 1'b1; oneshot[1] = 1'b1;
    set_load(1, 32'd2); start = 4'b0010;
    step(); chk("t2_load", cur_count[63:32], 32'd2);
    steps(40);
    chk("t2_cnt", cur_count[63:32], 32'd0);
    chk("t2_running", {31'd0, running[1]}, 32'h0);
    chk("t2_irq", {31'd0, irq[1]}, 32'h1);
    steps(20);
    chk("t2_hold", cur_count[63:32], 32'd0);
    irq_clear = 4'b0010; step();

    // stop / resume and collisions; allow the prescaler to wrap first
    prescale = 8'd0; steps(260);
    count_down[2] = 1'b0; oneshot[2] = 1'b0;
    set_load(2, 32'd7); start = 4'b0100;
    step(); chk("t3_load", cur_count[95:64], 32'd7);
    steps(3); chk("t3_ten", cur_count[95:64], 32'd10);
    stop = 4'b0100; step();
    chk("t3_stop_hold", cur_count[95:64], 32'd10);
    chk("t3_stop_run", {31'd0, running[2]}, 32'h0);
    steps(5); chk("t3_still", cur_count[95:64], 32'd10);
    set_load(2, 32'd5); start = 4'b0100; stop = 4'b0100;
    step(); chk("t3_both_cnt", cur_count[95:64], 32'd5);
    chk("t3_both_run", {31'd0, running[2]}, 32'h0);
    count_down[2] = 1'b1; set_load(2, 32'd1); start = 4'b0100;
    step(); chk("t3_dn_load", cur_count[95:64], 32'd1);
    step(); chk("t3_dn_zero", cur_count[95:64], 32'd0);
    irq_clear = 4'b0100;
    step(); chk("t3_set_wins", {31'd0, irq[2]}, 32'h1);
    chk("t3_reload", cur_count[95:64], 32'd1);
    stop = 4'b0100; irq_clear = 4'b0100; step();

    // randomized mixed operation, masked then selectively unmasked
    irq_en = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      count_down[ch] = 1'($urandom_range(0, 1));
      oneshot[ch]    = 1'($urandom_range(0, 1));
      set_load(ch, count_down[ch] ? 32'($urandom_range(0, 40))
                                  : 32'hFFFF_FFFF - 32'($urandom_range(0, 40)));
    end
    start = 4'hF; step();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) irq_en = 4'b0100;
      if (c < 1500 && c % 100 == 99) chk("t4_masked_any", {31'd0, irq_any}, 32'h0);
      for (int ch = 0; ch < 4; ch++) begin
        w = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40))
                                        : 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        set_load(ch, w);
        if ($urandom_range(0, 31) == 0) start[ch] = 1'b1;
        if ($urandom_range(0, 79) == 0) stop[ch] = 1'b1;
        if ($urandom_range(0, 19) == 0) irq_clear[ch] = 1'b1;
        if ($urandom_range(0, 99) == 0) count_down[ch] = ~count_down[ch];
        if ($urandom_range(0, 99) == 0) oneshot[ch] = ~oneshot[ch];
      end
      if ($urandom_range(0, 299) == 0) prescale = 8'($urandom_range(0, 3));
      step();
    end

    // asynchronous reset while every channel is running
    count_down = 4'hF; oneshot = 4'h0;
    for (int ch = 0; ch < 4; ch++) set_load(ch, 32'd1000);
    start = 4'hF; step(); steps(5);
    chk("t5_pre_running", {28'd0, running}, 32'hF);
    @(posedge clk); #2 rstn = 1'b0; #1;
    for (int ch = 0; ch < 4; ch++) chk("t5_async_cnt", cur_count[ch*32 +: 32], 32'h0);
    chk("t5_async_run", {28'd0, running}, 32'h0);
    chk("t5_async_irq", {28'd0, irq}, 32'h0);
    chk("t5_async_any", {31'd0, irq_any}, 32'h0);
    steps(2); rstn = 1'b1;
    steps(10);
    chk("t5_idle_run", {28'd0, running}, 32'h0);
    chk("t5_idle_cnt", cur_count[31:0], 32'h0);

    // narrow instance: 8-bit up periodic from 0xF0, irq cleared every cycle
    load_b = 8'hF0; oneshot_b = 1'b0; count_down_b = 1'b0; irq_clear_b = 1'b1;
    start_b = 1'b1; step();
    for (int k = 0; k < 80; k++) begin
      chk("t6_cnt", {24'd0, cur_b}, 32'(8'hF0 + 8'(k % 16)));
      chk("t6_irq", {31'd0, irq_b}, (k > 0 && k % 16 == 0) ? 32'h1 : 32'h0);
      chk("t6_running", {31'd0, running_b}, 32'h1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
